// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall control for the ID/EX boundary.
// Define FWD_STALL_COUNT_EN to build the saturating stall-cycle counter on stall_cnt.
module fwd_hazard_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_load,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic op_match(input logic use_op, input logic wr,
                                    input logic [REG_AW-1:0] dest, input logic [REG_AW-1:0] addr);
    return use_op && wr && (dest == addr) && (addr != {REG_AW{1'b0}});
  endfunction

  // Returns {sel, data}; a load in EX is never a source, so it falls through to MEM/history/RF.
  function automatic logic [DATA_W+1:0] resolve(
    input logic [REG_AW-1:0]                   addr,
    input logic                                use_op,
    input logic [DATA_W-1:0]                   rf_data,
    input logic                                ex_hit,
    input logic                                ex_is_load,
    input logic [DATA_W-1:0]                   ex_data,
    input logic                                mem_hit,
    input logic [DATA_W-1:0]                   mem_data,
    input logic [HIST_DEPTH-1:0]               hv,
    input logic [HIST_DEPTH-1:0][REG_AW-1:0]   hd,
    input logic [HIST_DEPTH-1:0][DATA_W-1:0]   hdata
  );
    logic              hist_hit;
    logic [DATA_W-1:0] hist_val;
    logic [1:0]        sel;
    logic [DATA_W-1:0] val;
    hist_hit = 1'b0;
    hist_val = rf_data;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (op_match(use_op, hv[i], hd[i], addr)) begin
        hist_hit = 1'b1;
        hist_val = hdata[i];
      end else begin
        hist_hit = hist_hit;
        hist_val = hist_val;
      end
    end
    if (ex_hit && !ex_is_load) begin
      sel = 2'd1;
      val = ex_data;
    end else if (mem_hit) begin
      sel = 2'd2;
      val = mem_data;
    end else if (hist_hit) begin
      sel = 2'd3;
      val = hist_val;
    end else begin
      sel = 2'd0;
      val = rf_data;
    end
    return {sel, val};
  endfunction

  logic [HIST_DEPTH-1:0]             hist_valid_r;
  logic [HIST_DEPTH-1:0][REG_AW-1:0] hist_dest_r;
  logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_data_r;
  logic                              ex_hit_a_s, ex_hit_b_s, mem_hit_a_s, mem_hit_b_s;
  logic                              hazard_s;
  logic [DATA_W+1:0]                 res_a_s, res_b_s;
  state_t                            state_r, state_nxt_s;
  logic [2:0]                        cnt_r, cnt_nxt_s;
  logic                              stall_s;

  assign ex_hit_a_s  = op_match(id_use_rs, ex_wr, ex_dest, id_rs);
  assign ex_hit_b_s  = op_match(id_use_rt, ex_wr, ex_dest, id_rt);
  assign mem_hit_a_s = op_match(id_use_rs, mem_wr, mem_dest, id_rs);
  assign mem_hit_b_s = op_match(id_use_rt, mem_wr, mem_dest, id_rt);
  assign hazard_s    = (ex_hit_a_s || ex_hit_b_s) && ex_load;

  assign res_a_s = resolve(id_rs, id_use_rs, rf_rs_data, ex_hit_a_s, ex_load, ex_result,
                           mem_hit_a_s, mem_result, hist_valid_r, hist_dest_r, hist_data_r);
  assign res_b_s = resolve(id_rt, id_use_rt, rf_rt_data, ex_hit_b_s, ex_load, ex_result,
                           mem_hit_b_s, mem_result, hist_valid_r, hist_dest_r, hist_data_r);

  // Operand outputs; reset forces the plain register-file path.
  always_comb begin
    if (reset) begin
      op_a      = rf_rs_data;
      op_b      = rf_rt_data;
      fwd_sel_a = 2'd0;
      fwd_sel_b = 2'd0;
    end else begin
      {fwd_sel_a, op_a} = res_a_s;
      {fwd_sel_b, op_b} = res_b_s;
    end
  end

  // Retired-write history; shifts every cycle, stall or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_valid_r <= {HIST_DEPTH{1'b0}};
      hist_dest_r  <= {(HIST_DEPTH*REG_AW){1'b0}};
      hist_data_r  <= {(HIST_DEPTH*DATA_W){1'b0}};
    end else begin
      for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
        hist_valid_r[i] <= hist_valid_r[i-1];
        hist_dest_r[i]  <= hist_dest_r[i-1];
        hist_data_r[i]  <= hist_data_r[i-1];
      end
      hist_valid_r[0] <= mem_wr && (mem_dest != {REG_AW{1'b0}});
      hist_dest_r[0]  <= mem_dest;
      hist_data_r[0]  <= mem_result;
    end
  end

  // Stall FSM state and countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Stall FSM next state; HOLD ignores new hazards since EX carries bubbles then.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (hazard_s) begin
          stall_s = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt_s = HOLD;
            cnt_nxt_s   = 3'(LOAD_LAT - 1);
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      HOLD: begin
        stall_s   = 1'b1;
        cnt_nxt_s = cnt_r - 3'd1;
        if (cnt_r <= 3'd1) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  assign stall = stall_s && !reset;

`ifdef FWD_STALL_COUNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
    end else if (stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
